// File: rtl/fta_bridge_downsize_pkg.sv
// Shared FTA bus types, sizes and helpers for the width-reducing bridge.
// Payload structs are sized for the widest supported port pair (256-bit wide, 64-bit narrow).
package fta_bridge_downsize_pkg;

  localparam int unsigned FTA_WIDE_MAX   = 256;
  localparam int unsigned FTA_NARROW_MAX = 64;
  localparam int unsigned FTA_WSEL       = FTA_WIDE_MAX / 8;
  localparam int unsigned FTA_NSEL       = FTA_NARROW_MAX / 8;
  localparam int unsigned FTA_ADR_W      = 32;
  localparam int unsigned FTA_TID_W      = 8;
  localparam int unsigned FTA_MAX_LANES  = 8;

  // Transfer size as log2 of the byte count
  typedef enum logic [2:0] {
    SZ_BYTE  = 3'd0,
    SZ_WYDE  = 3'd1,
    SZ_TETRA = 3'd2,
    SZ_OCTA  = 3'd3,
    SZ_HEXI  = 3'd4,
    SZ_32B   = 3'd5,
    SZ_64B   = 3'd6,
    SZ_128B  = 3'd7
  } fta_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } downsize_state_t;

  typedef struct packed {
    logic [4:0]              cmd;
    logic [FTA_TID_W-1:0]    tid;
    logic                    cyc;
    logic                    stb;
    logic                    we;
    fta_size_t               sz;
    logic [15:0]             asid;
    logic [7:0]              pl;
    logic [3:0]              pri;
    logic [3:0]              cache;
    logic                    csr;
    logic [FTA_ADR_W-1:0]    vadr;
    logic [FTA_ADR_W-1:0]    padr;
    logic [FTA_WSEL-1:0]     sel;
    logic [FTA_WIDE_MAX-1:0] data1;
  } fta_cmd_request128_t;

  typedef struct packed {
    logic [FTA_TID_W-1:0]    tid;
    logic                    ack;
    logic                    err;
    logic                    rty;
    logic                    stall;
    logic [3:0]              pri;
    logic [FTA_ADR_W-1:0]    adr;
    logic [FTA_WIDE_MAX-1:0] dat;
  } fta_cmd_response128_t;

  typedef struct packed {
    logic [4:0]                cmd;
    logic [FTA_TID_W-1:0]      tid;
    logic                      cyc;
    logic                      stb;
    logic                      we;
    fta_size_t                 sz;
    logic [15:0]               asid;
    logic [7:0]                pl;
    logic [3:0]                pri;
    logic [3:0]                cache;
    logic                      csr;
    logic [FTA_ADR_W-1:0]      vadr;
    logic [FTA_ADR_W-1:0]      padr;
    logic [FTA_NSEL-1:0]       sel;
    logic [FTA_NARROW_MAX-1:0] dat;
  } fta_cmd_request64_t;

  typedef struct packed {
    logic [FTA_TID_W-1:0]      tid;
    logic                      ack;
    logic                      err;
    logic                      rty;
    logic                      stall;
    logic [3:0]                pri;
    logic [FTA_ADR_W-1:0]      adr;
    logic [FTA_NARROW_MAX-1:0] dat;
  } fta_cmd_response64_t;

  // Limit a transfer size to what the narrow port can carry in one beat
  function automatic fta_size_t fta_size_clamp(input fta_size_t sz, input int unsigned max_log2);
    if (32'(sz) > max_log2) return fta_size_t'(3'(max_log2));
    return sz;
  endfunction

endpackage

// File: rtl/fta_bridge_downsize_if.sv
// Wide master-side and narrow slave-side FTA buses of one downsizing bridge.
interface fta_bridge_downsize_if;
  import fta_bridge_downsize_pkg::*;

  fta_cmd_request128_t  req_i;
  fta_cmd_response128_t resp_o;
  fta_cmd_request64_t   req_o;
  fta_cmd_response64_t  resp_i;

  // slave: the bridge itself; master: the surrounding environment
  modport slave  (input req_i, input resp_i, output resp_o, output req_o);
  modport master (output req_i, output resp_i, input resp_o, input req_o);
endinterface

// File: rtl/fta_bridge_downsize_lane_picker.sv
// Priority encoder: lowest set lane of a mask, plus a flag when the mask is empty.
module fta_lane_picker #(
  parameter int unsigned NLANES = 2
) (
  input  logic [NLANES-1:0]         mask,
  output logic [$clog2(NLANES)-1:0] lane_c,
  output logic                      none_c
);
  localparam int unsigned LW = $clog2(NLANES);

  always_comb begin
    lane_c = '0;
    none_c = 1'b1;
    for (int unsigned k = 0; k < NLANES; k++) begin
      if (mask[k] && none_c) begin
        lane_c = LW'(k);
        none_c = 1'b0;
      end
    end
  end
endmodule

// File: rtl/fta_bridge_downsize.sv
// Splits each wide FTA request into per-lane narrow beats and returns one
// reassembled wide response. Outputs are registered from the next-state logic.
module fta_bridge_downsize
  import fta_bridge_downsize_pkg::*;
#(
  parameter int unsigned WID_IN  = 128,
  parameter int unsigned WID_OUT = 64
) (
  input  logic                  rst_i,
  input  logic                  clk_i,
  fta_bridge_downsize_if.slave  bus,
  output logic                  busy_o
);
  localparam int unsigned NLANES = WID_IN / WID_OUT;
  localparam int unsigned NB     = WID_OUT / 8;
  localparam int unsigned LW     = $clog2(NLANES);
  localparam int unsigned AOUT   = $clog2(WID_OUT / 8);

  downsize_state_t      state, state_d;
  fta_cmd_request128_t  lat, lat_d;
  logic [NLANES-1:0]    mask, mask_d, in_mask, pick_mask;
  logic [LW-1:0]        lane, lane_d, pick_lane;
  logic                 pick_none;
  logic [WID_IN-1:0]    rdbuf, rdbuf_d;
  fta_cmd_request64_t   req_q, req_d;
  fta_cmd_response128_t resp_q, resp_d;
  logic                 busy_q;
  logic                 unused;

  // Keep the wide line base, substitute the lane index for the narrow word offset
  function automatic logic [FTA_ADR_W-1:0] lane_adr(input logic [FTA_ADR_W-1:0] a,
                                                    input logic [LW-1:0] ln);
    return (a & ~FTA_ADR_W'(WID_IN / 8 - 1)) | (FTA_ADR_W'(ln) << AOUT);
  endfunction

  function automatic fta_cmd_request64_t beat(input fta_cmd_request128_t r, input logic [LW-1:0] ln);
    fta_cmd_request64_t o;
    o       = '0;
    o.cmd   = r.cmd;
    o.tid   = r.tid;
    o.cyc   = 1'b1;
    o.stb   = 1'b1;
    o.we    = r.we;
    o.sz    = fta_size_clamp(r.sz, AOUT);
    o.asid  = r.asid;
    o.pl    = r.pl;
    o.pri   = r.pri;
    o.cache = r.cache;
    o.csr   = r.csr;
    o.vadr  = lane_adr(r.vadr, ln);
    o.padr  = lane_adr(r.padr, ln);
    o.sel   = FTA_NSEL'(r.sel[ln*NB +: NB]);
    o.dat   = FTA_NARROW_MAX'(r.data1[ln*WID_OUT +: WID_OUT]);
    return o;
  endfunction

  function automatic fta_cmd_response128_t wide_resp(input fta_cmd_request128_t r,
                                                     input logic [WID_IN-1:0] d);
    fta_cmd_response128_t o;
    o     = '0;
    o.tid = r.tid;
    o.pri = r.pri;
    o.adr = r.padr;
    o.dat = FTA_WIDE_MAX'(d);
    return o;
  endfunction

  // One lane is active when any of its byte selects is set
  always_comb begin
    in_mask = '0;
    for (int unsigned k = 0; k < NLANES; k++) in_mask[k] = |bus.req_i.sel[k*NB +: NB];
  end

  // In IDLE pick from the incoming request, otherwise from the mask minus the finished lane
  assign pick_mask = (state == IDLE) ? in_mask : (mask & ~(NLANES'(1) << lane));

  fta_lane_picker #(.NLANES(NLANES)) u_pick (
    .mask   (pick_mask),
    .lane_c (pick_lane),
    .none_c (pick_none)
  );

  always_comb begin
    state_d = state;
    lat_d   = lat;
    mask_d  = mask;
    lane_d  = lane;
    rdbuf_d = rdbuf;
    req_d   = req_q;
    resp_d  = '0;
    unique case (state)
      IDLE: begin
        req_d = '0;
        if (bus.req_i.cyc && bus.req_i.stb) begin
          lat_d   = bus.req_i;
          rdbuf_d = '0;
          mask_d  = in_mask;
          if (pick_none) begin
            state_d    = RESP;
            resp_d     = wide_resp(bus.req_i, '0);
            resp_d.ack = 1'b1;
          end else begin
            lane_d  = pick_lane;
            state_d = ISSUE;
            req_d   = beat(bus.req_i, pick_lane);
          end
        end
      end
      ISSUE: begin
        if (!bus.resp_i.stall) begin
          req_d.stb = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // err beats rty beats ack when several arrive together
        if (bus.resp_i.tid == lat.tid) begin
          if (bus.resp_i.err || bus.resp_i.rty) begin
            state_d    = RESP;
            req_d      = '0;
            resp_d     = wide_resp(lat, rdbuf);
            resp_d.err = bus.resp_i.err;
            resp_d.rty = !bus.resp_i.err;
          end else if (bus.resp_i.ack) begin
            rdbuf_d[lane*WID_OUT +: WID_OUT] = bus.resp_i.dat[WID_OUT-1:0];
            mask_d = pick_mask;
            if (pick_none) begin
              state_d    = RESP;
              req_d      = '0;
              resp_d     = wide_resp(lat, rdbuf_d);
              resp_d.ack = 1'b1;
            end else begin
              lane_d  = pick_lane;
              state_d = ISSUE;
              req_d   = beat(lat, pick_lane);
            end
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        req_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    resp_d.stall = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      lat    <= '0;
      mask   <= '0;
      lane   <= '0;
      rdbuf  <= '0;
      req_q  <= '0;
      resp_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_d;
      lat    <= lat_d;
      mask   <= mask_d;
      lane   <= lane_d;
      rdbuf  <= rdbuf_d;
      req_q  <= req_d;
      resp_q <= resp_d;
      busy_q <= (state_d != IDLE);
    end
  end

  assign bus.req_o  = req_q;
  assign bus.resp_o = resp_q;
  assign busy_o     = busy_q;

  // Fields the bridge never consumes in a given configuration
  assign unused = ^{lat, bus.req_i, bus.resp_i};

endmodule

// File: tb/tb_fta_bridge_downsize.sv
// Directed bench for fta_bridge_downsize: a 128->64 instance and a 256->32 instance.
module tb_fta_bridge_downsize;
  import fta_bridge_downsize_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic dsel;
  logic busy0, busy1, busy;
  fta_cmd_request128_t  mreq;
  fta_cmd_response64_t  sresp;
  fta_cmd_request64_t   nreq;
  fta_cmd_response128_t wresp;

  fta_bridge_downsize_if if0 ();
  fta_bridge_downsize_if if1 ();

  assign if0.req_i  = (dsel == 1'b0) ? mreq  : '0;
  assign if0.resp_i = (dsel == 1'b0) ? sresp : '0;
  assign if1.req_i  = (dsel == 1'b1) ? mreq  : '0;
  assign if1.resp_i = (dsel == 1'b1) ? sresp : '0;
  assign nreq  = dsel ? if1.req_o  : if0.req_o;
  assign wresp = dsel ? if1.resp_o : if0.resp_o;
  assign busy  = dsel ? busy1 : busy0;

  fta_bridge_downsize #(.WID_IN(128), .WID_OUT(64)) u_dut0 (
    .rst_i (rst), .clk_i (clk), .bus (if0.slave), .busy_o (busy0)
  );
  fta_bridge_downsize #(.WID_IN(256), .WID_OUT(32)) u_dut1 (
    .rst_i (rst), .clk_i (clk), .bus (if1.slave), .busy_o (busy1)
  );

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int t_acc = 0;
  int n_ack, n_err, n_beats, n_cyc;
  logic [7:0] cur_tid;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Passive monitor: counts responses, accepted narrow beats and cycles with cyc high
  always @(negedge clk) begin
    if (wresp.ack) n_ack++;
    if (wresp.err) n_err++;
    if (nreq.cyc) n_cyc++;
    if (nreq.cyc && nreq.stb && !sresp.stall) n_beats++;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    n_ack = 0; n_err = 0; n_beats = 0; n_cyc = 0;
  endtask

  task automatic send(input logic [7:0] tid, input logic we, input logic [31:0] sel,
                      input logic [31:0] padr, input logic [255:0] data, input fta_size_t sz);
    mreq       = '0;
    mreq.cmd   = 5'h3;
    mreq.tid   = tid;
    mreq.cyc   = 1'b1;
    mreq.stb   = 1'b1;
    mreq.we    = we;
    mreq.sz    = sz;
    mreq.asid  = 16'h00A5;
    mreq.pl    = 8'h7;
    mreq.pri   = 4'h5;
    mreq.cache = 4'h2;
    mreq.padr  = padr;
    mreq.vadr  = padr ^ 32'h8000_0000;
    mreq.sel   = sel;
    mreq.data1 = data;
    cur_tid    = tid;
    tick();
    t_acc    = cyc_cnt;
    mreq.cyc = 1'b0;
    mreq.stb = 1'b0;
  endtask

  // Play the narrow slave for one beat: kind 0 ack, 1 err, 2 rty
  task automatic beat(input string tag, input logic [31:0] exp_padr, input logic [7:0] exp_sel,
                      input logic [63:0] exp_dat, input logic exp_we, input fta_size_t exp_sz,
                      input logic [63:0] rdat, input int nstall, input int kind, input logic wrong_tid);
    int n = 0;
    while (!(nreq.cyc && nreq.stb) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_stb"},  512'(nreq.stb),  512'(1'b1));
    chk({tag, "_padr"}, 512'(nreq.padr), 512'(exp_padr));
    chk({tag, "_vadr"}, 512'(nreq.vadr), 512'(exp_padr ^ 32'h8000_0000));
    chk({tag, "_sel"},  512'(nreq.sel),  512'(exp_sel));
    chk({tag, "_dat"},  512'(nreq.dat),  512'(exp_dat));
    chk({tag, "_we"},   512'(nreq.we),   512'(exp_we));
    chk({tag, "_sz"},   512'(nreq.sz),   512'(exp_sz));
    chk({tag, "_tid"},  512'(nreq.tid),  512'(cur_tid));
    if (nstall > 0) sresp.stall = 1'b1;
    for (int i = 0; i < nstall; i++) begin
      tick();
      chk({tag, "_hold_stb"},  512'(nreq.stb),  512'(1'b1));
      chk({tag, "_hold_padr"}, 512'(nreq.padr), 512'(exp_padr));
    end
    sresp.stall = 1'b0;
    tick();
    chk({tag, "_wait_stb"}, 512'(nreq.stb), 512'(1'b0));
    chk({tag, "_wait_cyc"}, 512'(nreq.cyc), 512'(1'b1));
    if (wrong_tid) begin
      sresp.ack = 1'b1;
      sresp.tid = cur_tid ^ 8'hFF;
      sresp.dat = ~rdat;
      tick();
      sresp = '0;
      chk({tag, "_wrongtid_stb"}, 512'(nreq.stb), 512'(1'b0));
    end
    sresp.tid = cur_tid;
    sresp.dat = rdat;
    sresp.ack = (kind == 0);
    sresp.err = (kind == 1);
    sresp.rty = (kind == 2);
    tick();
    sresp = '0;
  endtask

  logic [255:0] wd, e8;

  initial begin
    rst = 1'b1; dsel = 1'b0; mreq = '0; sresp = '0; cur_tid = '0;
    clr_mon();
    tick(); tick();
    chk("rst_req0",  512'(if0.req_o),  512'(0));
    chk("rst_resp0", 512'(if0.resp_o), 512'(0));
    chk("rst_busy0", 512'(busy0),      512'(0));
    chk("rst_req1",  512'(if1.req_o),  512'(0));
    chk("rst_busy1", 512'(busy1),      512'(0));
    rst = 1'b0;
    tick();

    // 128->64 full-width read
    clr_mon();
    send(8'h11, 1'b0, 32'h0000_FFFF, 32'h1000, '0, SZ_HEXI);
    chk("s1_busy",  512'(busy),        512'(1));
    chk("s1_stall", 512'(wresp.stall), 512'(1));
    beat("s1b0", 32'h1000, 8'hFF, 64'h0, 1'b0, SZ_OCTA, 64'hAAAA_AAAA_AAAA_AAAA, 0, 0, 1'b0);
    beat("s1b1", 32'h1008, 8'hFF, 64'h0, 1'b0, SZ_OCTA, 64'h5555_5555_5555_5555, 0, 0, 1'b0);
    chk("s1_ack", 512'(wresp.ack), 512'(1));
    chk("s1_dat", 512'(wresp.dat), 512'({64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA}));
    chk("s1_tid", 512'(wresp.tid), 512'(8'h11));
    chk("s1_adr", 512'(wresp.adr), 512'(32'h1000));
    chk("s1_pri", 512'(wresp.pri), 512'(4'h5));
    // Ack is on the bus during the 5th cycle after the acceptance edge
    chk("s1_latency", 512'(cyc_cnt - t_acc), 512'(4));
    tick();
    chk("s1_ack_drop", 512'(wresp.ack),   512'(0));
    chk("s1_idle",     512'(busy),        512'(0));
    chk("s1_nostall",  512'(wresp.stall), 512'(0));
    chk("s1_nack",     512'(n_ack),       512'(1));
    chk("s1_nbeats",   512'(n_beats),     512'(2));

    // 128->64 single-lane write
    clr_mon();
    wd = '0;
    wd[95:64] = 32'hDEAD_BEEF;
    send(8'h22, 1'b1, 32'h0000_0F00, 32'h2000, wd, SZ_TETRA);
    beat("s2b0", 32'h2008, 8'h0F, 64'h0000_0000_DEAD_BEEF, 1'b1, SZ_TETRA, 64'h0, 0, 0, 1'b0);
    chk("s2_ack",     512'(wresp.ack),        512'(1));
    chk("s2_tid",     512'(wresp.tid),        512'(8'h22));
    chk("s2_latency", 512'(cyc_cnt - t_acc),  512'(2));
    tick();
    chk("s2_nack",   512'(n_ack),   512'(1));
    chk("s2_nbeats", 512'(n_beats), 512'(1));

    // Empty byte select: immediate ack, no downstream access
    clr_mon();
    send(8'h33, 1'b0, 32'h0, 32'h3000, '0, SZ_OCTA);
    chk("s3_ack",  512'(wresp.ack), 512'(1));
    chk("s3_tid",  512'(wresp.tid), 512'(8'h33));
    chk("s3_dat",  512'(wresp.dat), 512'(0));
    chk("s3_busy", 512'(busy),      512'(1));
    tick();
    chk("s3_ack_drop", 512'(wresp.ack), 512'(0));
    chk("s3_idle",     512'(busy),      512'(0));
    chk("s3_nocyc",    512'(n_cyc),     512'(0));
    chk("s3_nack",     512'(n_ack),     512'(1));

    // Error on beat 0 aborts the second lane
    clr_mon();
    send(8'h44, 1'b0, 32'h0000_FFFF, 32'h3000, '0, SZ_HEXI);
    beat("s4b0", 32'h3000, 8'hFF, 64'h0, 1'b0, SZ_OCTA, 64'h1, 0, 1, 1'b0);
    chk("s4_err", 512'(wresp.err), 512'(1));
    chk("s4_ack", 512'(wresp.ack), 512'(0));
    chk("s4_tid", 512'(wresp.tid), 512'(8'h44));
    chk("s4_cyc", 512'(nreq.cyc),  512'(0));
    tick(); tick(); tick();
    chk("s4_nbeats", 512'(n_beats), 512'(1));
    chk("s4_nerr",   512'(n_err),   512'(1));
    chk("s4_nack",   512'(n_ack),   512'(0));

    // Slave stalls beat 1 for three cycles
    clr_mon();
    send(8'h45, 1'b0, 32'h0000_FFFF, 32'h5000, '0, SZ_OCTA);
    beat("s5b0", 32'h5000, 8'hFF, 64'h0, 1'b0, SZ_OCTA, 64'h0123_4567_89AB_CDEF, 0, 0, 1'b0);
    beat("s5b1", 32'h5008, 8'hFF, 64'h0, 1'b0, SZ_OCTA, 64'hFEDC_BA98_7654_3210, 3, 0, 1'b0);
    chk("s5_ack",     512'(wresp.ack),       512'(1));
    chk("s5_dat",     512'(wresp.dat),       512'({64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}));
    chk("s5_latency", 512'(cyc_cnt - t_acc), 512'(7));
    tick();

    // Wrong-tid ack during WAIT is ignored
    clr_mon();
    send(8'h46, 1'b0, 32'h0000_FFFF, 32'h6000, '0, SZ_OCTA);
    beat("s6b0", 32'h6000, 8'hFF, 64'h0, 1'b0, SZ_OCTA, 64'h1111_2222_3333_4444, 0, 0, 1'b1);
    beat("s6b1", 32'h6008, 8'hFF, 64'h0, 1'b0, SZ_OCTA, 64'h5555_6666_7777_8888, 0, 0, 1'b0);
    chk("s6_ack",     512'(wresp.ack),       512'(1));
    chk("s6_dat",     512'(wresp.dat),       512'({64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444}));
    chk("s6_latency", 512'(cyc_cnt - t_acc), 512'(5));
    tick();
    chk("s6_nack", 512'(n_ack), 512'(1));

    // Reset while waiting for a beat response
    clr_mon();
    send(8'h55, 1'b0, 32'h0000_FFFF, 32'h7000, '0, SZ_OCTA);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s7_cyc",  512'(nreq.cyc),  512'(0));
    chk("s7_busy", 512'(busy),      512'(0));
    chk("s7_ack",  512'(wresp.ack), 512'(0));
    tick(); tick();
    chk("s7_nack", 512'(n_ack), 512'(0));
    send(8'h56, 1'b0, 32'h0000_00FF, 32'h4000, '0, SZ_OCTA);
    beat("s7b0", 32'h4000, 8'hFF, 64'h0, 1'b0, SZ_OCTA, 64'h1234, 0, 0, 1'b0);
    chk("s7_after_ack", 512'(wresp.ack), 512'(1));
    chk("s7_after_dat", 512'(wresp.dat), 512'(128'h1234));
    chk("s7_after_tid", 512'(wresp.tid), 512'(8'h56));
    tick();

    // 256->32: only lanes 0 and 3 are active
    dsel = 1'b1;
    tick();
    clr_mon();
    e8 = '0;
    e8[31:0]   = 32'hAAAA_AAAA;
    e8[127:96] = 32'h5555_5555;
    send(8'h66, 1'b0, 32'h0000_F00F, 32'h1010, '0, SZ_32B);
    beat("s8b0", 32'h1000, 8'h0F, 64'h0, 1'b0, SZ_TETRA, 64'hAAAA_AAAA, 0, 0, 1'b0);
    beat("s8b3", 32'h100C, 8'h0F, 64'h0, 1'b0, SZ_TETRA, 64'h5555_5555, 0, 0, 1'b0);
    chk("s8_ack",     512'(wresp.ack),       512'(1));
    chk("s8_dat",     512'(wresp.dat),       512'(e8));
    chk("s8_adr",     512'(wresp.adr),       512'(32'h1010));
    chk("s8_latency", 512'(cyc_cnt - t_acc), 512'(4));
    tick();
    chk("s8_nbeats", 512'(n_beats), 512'(2));
    chk("s8_nack",   512'(n_ack),   512'(1));
    chk("s8_idle",   512'(busy),    512'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
